// File: rtl/spi_cfg_rx.sv
// spi_cfg_rx: collects (delay, object ID) beats into an indexed configuration
// table. It tracks which objects have arrived and flags the frame complete
// once every object ID has been seen.
module spi_cfg_rx #(
  parameter int delay_length = 14,
  parameter int obj_id_width = 2,
  parameter int N_obj        = 4
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [delay_length-1:0]       delay_matrix_element,
  input  logic [obj_id_width-1:0]       obj_id_element,
  output logic                          in_ready,
  output logic [N_obj*delay_length-1:0] cfg_delay,
  output logic [N_obj-1:0]              cfg_active,
  output logic                          cfg_valid,
  output logic                          done,
  output logic                          frm_err,
  input  logic [obj_id_width-1:0]       rd_id,
  output logic [delay_length-1:0]       rd_delay
);

  localparam logic [obj_id_width:0] ID_LIM = N_obj[obj_id_width:0];

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [N_obj-1:0]        r_rx_mask, w_mask_nxt;
  logic [delay_length-1:0] r_table [N_obj];
  logic                    r_done, w_done_nxt;
  logic                    r_frm_err, w_frm_err_nxt;
  logic [delay_length-1:0] r_rd_delay;
  logic                    w_id_ok, w_rd_ok, w_wr;

  // State register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, receive mask, error flag and completion pulse
  always_comb begin
    w_state_nxt   = r_state;
    w_mask_nxt    = r_rx_mask;
    w_frm_err_nxt = r_frm_err;
    w_wr          = 1'b0;
    w_id_ok       = ({1'b0, obj_id_element} < ID_LIM);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_RECV;
          w_mask_nxt    = '0;
          w_frm_err_nxt = 1'b0;
        end
      end
      S_RECV: begin
        // start wins over a simultaneous beat; the beat is dropped
        if (start) begin
          w_mask_nxt    = '0;
          w_frm_err_nxt = 1'b0;
        end else if (in_valid) begin
          if (w_id_ok && !r_rx_mask[obj_id_element]) begin
            w_wr                       = 1'b1;
            w_mask_nxt[obj_id_element] = 1'b1;
            if (&w_mask_nxt) w_state_nxt = S_DONE;
          end else begin
            w_frm_err_nxt = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_nxt   = S_RECV;
          w_mask_nxt    = '0;
          w_frm_err_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_done_nxt = (r_state == S_RECV) && (w_state_nxt == S_DONE);
  end

  // Mask, error flag and completion pulse registers
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_rx_mask <= '0;
      r_frm_err <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rx_mask <= w_mask_nxt;
      r_frm_err <= w_frm_err_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Configuration table; contents persist across frames until overwritten
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_obj; i++) r_table[i] <= '0;
    end else if (w_wr) begin
      r_table[obj_id_element] <= delay_matrix_element;
    end
  end

  assign w_rd_ok = ({1'b0, rd_id} < ID_LIM);

  // Registered read port; a same-edge write returns the old entry
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)       r_rd_delay <= '0;
    else if (w_rd_ok) r_rd_delay <= r_table[rd_id];
    else              r_rd_delay <= '0;
  end

  // Flattened table and per-object active flags (all-ones marks disabled)
  always_comb begin
    cfg_delay  = '0;
    cfg_active = '0;
    for (int unsigned i = 0; i < N_obj; i++) begin
      cfg_delay[i*delay_length +: delay_length] = r_table[i];
      cfg_active[i] = r_rx_mask[i] && (r_table[i] != '1);
    end
  end

  assign in_ready  = (r_state == S_RECV);
  assign cfg_valid = (r_state == S_DONE);
  assign done      = r_done;
  assign frm_err   = r_frm_err;
  assign rd_delay  = r_rd_delay;

endmodule

// File: doc/spi_cfg_rx.md
# spi_cfg_rx

Receiving end of the delay/object-ID configuration stream that `spi_module` shifts out on `dft_clk_out`. Each beat carries one (delay, object ID) pair. The block collects one beat per object into an indexed configuration table and tracks which objects are present. It declares the frame complete once every object ID has been received. Downstream DRBE tap logic reads the table through a flattened bus or a registered read port.

## Interface
Parameters:
- `delay_length`, 14, width of one delay-matrix element.
- `obj_id_width`, 2, width of an object ID.
- `N_obj`, 4, number of objects per frame (≤ 2^obj_id_width).

Ports:
- `CLK`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  arms a new frame.
- `in_valid`  in  1  beat present on the element inputs.
- `delay_matrix_element`  in  delay_length  delay value of the beat.
- `obj_id_element`  in  obj_id_width  table index of the beat.
- `in_ready`  out  1  block accepts beats; high only in RECV.
- `cfg_delay`  out  N_obj*delay_length  table, entry i at bits [i*delay_length +: delay_length].
- `cfg_active`  out  N_obj  bit i = entry i received this frame and not equal to all-ones.
- `cfg_valid`  out  1  table complete; level signal.
- `done`  out  1  one-cycle completion pulse.
- `frm_err`  out  1  sticky frame error.
- `rd_id`  in  obj_id_width  read-port index.
- `rd_delay`  out  delay_length  registered read data.

## Operation
- The state machine has three states: IDLE, RECV and DONE. Reset enters IDLE.
- **IDLE:**
  - `in_ready` = 0.
  - `start` moves the block to RECV, clears `rx_mask` and clears `frm_err`.
- **RECV:**
  - `in_ready` = 1. A beat is accepted when `in_valid & in_ready`.
  - Accepted beat with `id < N_obj` and `rx_mask[id]` = 0: write `table[id]` = delay and set `rx_mask[id]`.
  - Accepted beat whose `rx_mask[id]` is already set (duplicate): the first value is kept, the beat is dropped and `frm_err` is set.
  - Accepted beat with `id ≥ N_obj`: the beat is dropped and `frm_err` is set.
  - When the updated `rx_mask` is all ones, the block moves to DONE at that same edge.
  - `start` while in RECV restarts the frame: `rx_mask` and `frm_err` are cleared. `start` has priority over a simultaneous beat, and that beat is dropped.
- **DONE:**
  - `in_ready` = 0 and `in_valid` is ignored.
  - `start` moves to RECV, clearing `cfg_valid`, `rx_mask` and `frm_err`.
- Table contents persist across frames until overwritten. Only reset clears them.
- `cfg_valid` = (state == DONE).
- `cfg_active[i]` = `rx_mask[i]` & (`table[i]` != all-ones). The value 14'h3fff marks a disabled object.
- Read port: `rd_delay` is registered `table[rd_id]` every cycle. When `rd_id ≥ N_obj`, `rd_delay` is 0.
- No arithmetic beyond the equality compare. Table width is exactly `delay_length`, with no truncation.

## Timing
- Reset (`reset` = 0, asynchronous): state = IDLE; `rx_mask`, table, `cfg_valid`, `cfg_active`, `done`, `frm_err` and `rd_delay` all = 0.
- Reset asserted mid-frame: every register clears immediately. The partial frame is lost, and a new `start` is required.
- `in_ready` rises in the cycle after the edge that samples `start`.
- Accepted beat: table and mask update at the sampling edge. `cfg_active` reflects the update one cycle later, because it is derived from registers.
- Last beat accepted at edge k: `cfg_valid` = 1 and `done` = 1 from edge k. `done` falls at edge k+1.
- Zero-bubble operation: back-to-back beats on consecutive cycles are accepted. Minimum frame length is N_obj cycles.
- Read latency is one cycle. A table write and a read of the same entry at the same edge returns the old value.
- Within a frame, `frm_err` never clears without a `start` or reset.

## Test plan
- Reset, `start`, then beats (10000,0), (10010,1), (14'h3fff,2), (14'h3fff,3) on consecutive cycles → a single `done` pulse after beat 4, `cfg_valid` = 1, `cfg_active` = 4'b0011, entry 0 = 10000, entry 1 = 10010, `frm_err` = 0.
- `start`, then beats (5,2), (7,2), (1,0), (2,1), (3,3) → `frm_err` = 1, entry 2 = 5, `done` after the fifth beat, `cfg_active` = 4'b1111.
- `start`, two beats, then `reset` low for one cycle → all outputs 0 and state IDLE. A beat presented after release without `start` is ignored (`in_ready` = 0).
- `start` asserted in the same cycle as a third beat → that beat is dropped, `rx_mask` = 0, and 4 new beats are required for `done`.
- After a complete frame, drive `rd_id` = 1 → `rd_delay` = 10010 one cycle later. `in_valid` pulses while in DONE leave the table unchanged.
- A second frame after `start` rewrites entry 0 = 200 → `cfg_valid` drops at `start` and returns at completion, with entry 0 = 200.
